// File: rtl/text_buffer.sv
// ---------------------------------------------------------------------------
// text_buffer
//
// Character screen store sitting between the character feeder and the VGA
// glyph renderer. Characters are stored in a block RAM addressed by physical
// row; a rotating "top" pointer maps logical rows to physical rows so that a
// scroll is a single pointer bump instead of a memory copy. Each physical
// row keeps a fill count (leading written columns); cells at or beyond the
// fill count read back as BLANK_CHAR. As a result, scroll and clear finish in
// one cycle without touching the RAM.
//
// Ports:
//   clock            system clock, everything on the rising edge
//   reset_n          synchronous active-low reset
//   wr_en/wr_row/wr_col/wr_char   write from the feeder (logical address)
//   push_up          scroll up by one line (old top line becomes blank bottom)
//   clear            logical clear of the whole screen, top back to 0
//   rd_en/rd_row/rd_col           read request from the renderer
//   rd_char/rd_valid read data and strobe, one cycle after rd_en
//   top_row          physical row currently shown as logical row 0
// ---------------------------------------------------------------------------
module text_buffer #(
    parameter int ROW_NUMBER  = 15,
    parameter int COL_NUMBER  = 40,
    parameter int ROW_BIT_LEN = 4,
    parameter int COL_BIT_LEN = 6,
    parameter int CHAR_ID_LEN = 8,
    parameter logic [CHAR_ID_LEN-1:0] BLANK_CHAR = 8'h20
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [ROW_BIT_LEN-1:0] wr_row,
    input  logic [COL_BIT_LEN-1:0] wr_col,
    input  logic [CHAR_ID_LEN-1:0] wr_char,
    input  logic                   push_up,
    input  logic                   clear,
    input  logic                   rd_en,
    input  logic [ROW_BIT_LEN-1:0] rd_row,
    input  logic [COL_BIT_LEN-1:0] rd_col,
    output logic [CHAR_ID_LEN-1:0] rd_char,
    output logic                   rd_valid,
    output logic [ROW_BIT_LEN-1:0] top_row
);

    localparam int CELLS  = ROW_NUMBER * COL_NUMBER;
    localparam int ADDR_W = $clog2(CELLS);

    localparam logic [ROW_BIT_LEN:0]   ROW_LIMIT = (ROW_BIT_LEN+1)'(ROW_NUMBER);
    localparam logic [COL_BIT_LEN:0]   COL_LIMIT = (COL_BIT_LEN+1)'(COL_NUMBER);
    localparam logic [ROW_BIT_LEN-1:0] LAST_ROW  = ROW_BIT_LEN'(ROW_NUMBER - 1);

    // Logical -> physical row: add without overflow, then fold once.
    function automatic logic [ROW_BIT_LEN-1:0] map_row(
        input logic [ROW_BIT_LEN-1:0] base,
        input logic [ROW_BIT_LEN-1:0] row
    );
        logic [ROW_BIT_LEN:0] sum;
        sum = {1'b0, base} + {1'b0, row};
        if (sum >= ROW_LIMIT)
            sum = sum - ROW_LIMIT;
        return sum[ROW_BIT_LEN-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(
        input logic [ROW_BIT_LEN-1:0] phys,
        input logic [COL_BIT_LEN-1:0] col
    );
        return ADDR_W'(phys) * ADDR_W'(COL_NUMBER) + ADDR_W'(col);
    endfunction

    // State
    logic [ROW_BIT_LEN-1:0]                   top_reg;
    logic [ROW_NUMBER-1:0][COL_BIT_LEN:0]     fill_reg;
    logic [ROW_NUMBER-1:0][COL_BIT_LEN:0]     fill_next;
    logic [CHAR_ID_LEN-1:0]                   mem [CELLS];
    logic [CHAR_ID_LEN-1:0]                   ram_q_reg;
    logic                                     rd_hit_reg;
    logic                                     rd_valid_reg;

    // Write path
    logic                   wr_in_range;
    logic                   wr_accept;
    logic [ROW_BIT_LEN-1:0] wr_phys;
    logic [ADDR_W-1:0]      wr_addr;
    logic [COL_BIT_LEN:0]   wr_span;

    assign wr_in_range = ({1'b0, wr_row} < ROW_LIMIT) && ({1'b0, wr_col} < COL_LIMIT);
    assign wr_accept   = wr_en && wr_in_range && !clear;
    // Write uses the pre-scroll top; a same-cycle push_up applies afterwards.
    assign wr_phys     = map_row(top_reg, wr_row);
    assign wr_addr     = cell_addr(wr_phys, wr_col);
    assign wr_span     = {1'b0, wr_col} + (COL_BIT_LEN+1)'(1);

    // Per-row fill update. Recycling the top row on push_up takes precedence
    // over a write landing on that same physical row.
    for (genvar gi = 0; gi < ROW_NUMBER; gi++) begin : g_fill
        logic recycle;
        logic grow;
        assign recycle = push_up && (top_reg == ROW_BIT_LEN'(gi));
        assign grow    = wr_accept && (wr_phys == ROW_BIT_LEN'(gi)) && (wr_span > fill_reg[gi]);
        assign fill_next[gi] = recycle ? '0 :
                               grow    ? wr_span : fill_reg[gi];
    end

    // Read path. Out-of-range requests are steered to a harmless address and
    // flagged as misses so they return BLANK_CHAR.
    logic                   rd_in_range;
    logic [ROW_BIT_LEN-1:0] rd_phys;
    logic [COL_BIT_LEN-1:0] rd_col_safe;
    logic                   rd_cell_ok;
    logic [ADDR_W-1:0]      rd_addr;

    assign rd_in_range = ({1'b0, rd_row} < ROW_LIMIT) && ({1'b0, rd_col} < COL_LIMIT);
    assign rd_phys     = rd_in_range ? map_row(top_reg, rd_row) : '0;
    assign rd_col_safe = rd_in_range ? rd_col : '0;
    assign rd_cell_ok  = rd_in_range && ({1'b0, rd_col} < fill_reg[rd_phys]);
    assign rd_addr     = cell_addr(rd_phys, rd_col_safe);

    // Character RAM: single write port, registered read-first read port.
    always_ff @(posedge clock) begin
        if (reset_n && wr_accept)
            mem[wr_addr] <= wr_char;
        if (rd_en)
            ram_q_reg <= mem[rd_addr];
    end

    // Control state
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            top_reg      <= '0;
            fill_reg     <= '0;
            rd_valid_reg <= 1'b0;
            rd_hit_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= rd_en;
            if (rd_en)
                rd_hit_reg <= rd_cell_ok;
            if (clear) begin
                top_reg  <= '0;
                fill_reg <= '0;
            end else begin
                fill_reg <= fill_next;
                if (push_up)
                    top_reg <= (top_reg == LAST_ROW) ? '0 : top_reg + ROW_BIT_LEN'(1);
            end
        end
    end

    // rd_hit_reg and ram_q_reg only change on rd_en, so rd_char holds
    // between reads; reset clears the hit flag, giving BLANK_CHAR.
    assign rd_char  = rd_hit_reg ? ram_q_reg : BLANK_CHAR;
    assign rd_valid = rd_valid_reg;
    assign top_row  = top_reg;

endmodule

// File: doc/text_buffer.md
Name: text_buffer

Overview:
Character screen store directly downstream of the character feeder. It captures each character at the (row, col) the feeder issues and implements scroll-up (push_up) as a circular row rotation. It implements clear (reset_call) as a single-cycle logical blank. A read port serves the VGA glyph renderer with logical (row, col) addressing and one-cycle latency.

Parameters:
ROW_NUMBER, 15, number of text lines
COL_NUMBER, 40, characters per line
ROW_BIT_LEN, 4, row address width
COL_BIT_LEN, 6, column address width
CHAR_ID_LEN, 8, character code width
BLANK_CHAR, 8'h20, code returned for unwritten cells

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
wr_en  input  1  write strobe from feeder
wr_row  input  ROW_BIT_LEN  logical row of write
wr_col  input  COL_BIT_LEN  logical column of write
wr_char  input  CHAR_ID_LEN  character code to store
push_up  input  1  scroll request: one-line scroll up
clear  input  1  clear request (feeder reset_call)
rd_en  input  1  read strobe from renderer
rd_row  input  ROW_BIT_LEN  logical row to read
rd_col  input  COL_BIT_LEN  logical column to read
rd_char  output  CHAR_ID_LEN  read data, valid one cycle after rd_en
rd_valid  output  1  high one cycle after an accepted rd_en
top_row  output  ROW_BIT_LEN  physical row currently shown as logical row 0

Behaviour:
- Storage: ROW_NUMBER*COL_NUMBER x CHAR_ID_LEN RAM, physical address = phys_row*COL_NUMBER + col.
- Row mapping: phys_row = (top + logical_row) mod ROW_NUMBER; no-overflow add then conditional subtract of ROW_NUMBER.
- Fill tracking: per physical row, fill[r] (COL_BIT_LEN+1 bits) = count of leading written columns. A cell is valid iff col < fill[phys_row]; invalid cells read as BLANK_CHAR. No per-cell RAM clearing, so the block is never busy and has no backpressure.
- Write (wr_en=1, wr_row<ROW_NUMBER, wr_col<COL_NUMBER): RAM[phys][wr_col] <= wr_char; if wr_col+1 > fill[phys] then fill[phys] <= wr_col+1. Out-of-range writes are ignored entirely.
- push_up=1: top <= (top+1) mod ROW_NUMBER; fill[old top] <= 0. The old top row becomes the new blank bottom row.
- clear=1: top <= 0; all fill <= 0; RAM untouched.
- Same-cycle priority:
  - clear overrides write and push_up; both are dropped.
  - write + push_up: the write uses the pre-scroll top, then the scroll applies. The feeder issues its final character at row 14 col 39 together with push_up, and that character must land on the line that becomes logical row 13.
  - If the write targets the physical row being recycled (logical row 0), its fill zeroing wins.
- Read: on rd_en, sample the mapped address. On the next cycle, rd_valid=1 and rd_char = RAM data, or BLANK_CHAR if the cell is invalid or rd_row/rd_col is out of range.
- Read-during-write: a read uses the top/fill/RAM state from before the same edge, i.e. it returns old data (read-first).
- rd_valid=0 in cycles with no prior rd_en; rd_char holds its last value.
- Reset (reset_n=0 at the edge): top=0, all fill=0, rd_valid=0, rd_char=BLANK_CHAR. RAM contents are undefined but masked by fill. Pending reads are discarded. Reset overrides all other inputs.
- top_row is a registered copy of top.

Test Plan:
1. Reset, then write 'A'(8'h41) at (0,0) and 'B' at (0,1); read (0,0),(0,1),(0,2) -> 8'h41, 8'h42, 8'h20, each with rd_valid one cycle after rd_en.
2. Fill all 600 cells with code = (row*40+col) mod 256, then read back every cell -> exact match; read (15,0) and (0,40) -> 8'h20.
3. Write (14,39)=8'h5A with push_up in the same cycle -> top_row=1; read (13,39)=8'h5A; all of row 14 reads 8'h20; old row 1 content now appears at logical row 0.
4. Do 15 consecutive push_up pulses -> top_row wraps 14->0; rows blanked in order; no stale data visible.
5. clear asserted with wr_en and push_up in the same cycle -> top_row=0; all cells read 8'h20; the dropped write is not visible afterwards.
6. Write (2,5)=8'h33 and read (2,5) on the same edge -> old value 8'h20 returned; next read -> 8'h33. Then assert reset_n=0 mid-read -> rd_valid=0 next cycle and all cells blank.
